// File: rtl/data_sync_tx_if.sv
// Producer-facing and destination-facing signals of the CDC bus transmitter.
// The slave modport is the transmitter's view; master is its environment.
interface data_sync_tx_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic                 ack_async;
  logic [BUS_WIDTH-1:0] Unsync_bus;
  logic                 bus_enable;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_data, i_valid, ack_async,
    input  o_ready, Unsync_bus, bus_enable, o_busy, o_done
  );

  modport slave (
    input  i_data, i_valid, ack_async,
    output o_ready, Unsync_bus, bus_enable, o_busy, o_done
  );
endinterface

// File: rtl/data_sync_tx.sv
// Source-domain side of a multi-bit CDC transfer: holds a word on Unsync_bus and
// runs a 4-phase bus_enable/ack handshake against a locally synchronised ack.
module data_sync_tx #(
  parameter int NUM_STAGES   = 2,
  parameter int BUS_WIDTH    = 8,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_sync_tx_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [NUM_STAGES-1:0]  ack_ff_q;
  logic                   ack_sync;
  logic [3:0]             cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   be_q, be_d;
  logic                   done_q, done_d;
  logic                   accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_ff_q <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      be_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ack_ff_q <= {ack_ff_q[NUM_STAGES-2:0], bus.ack_async};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      be_q     <= be_d;
      done_q   <= done_d;
    end
  end

  assign ack_sync = ack_ff_q[NUM_STAGES-1];
  // A stale ack still high in IDLE must drain before a new word is taken.
  assign accept   = bus.i_valid && (state_q == IDLE) && !ack_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    be_d    = be_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = bus.i_data;
          if (SETUP_CYCLES == 0) begin
            be_d    = 1'b1;
            state_d = REQ;
          end else begin
            cnt_d   = SETUP_LOAD;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          be_d    = 1'b1;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REQ: begin
        if (ack_sync) begin
          be_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ready    = (state_q == IDLE) && !ack_sync;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = done_q;
  assign bus.bus_enable = be_q;
  assign bus.Unsync_bus = data_q;

endmodule
